enemy_formation: RTL

Per-frame enemy grid controller for the invaders game. It owns the 60-enemy alive mask and marches the formation across and down the screen. It clears enemies on collision hits and accumulates score. It sits directly upstream of the game state machine: its `enemy_array` output is the mask that machine watches for the all-dead (you win) condition, and it runs only while the game state is "playing".

---
 rtl/enemy_formation.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/enemy_formation.sv
// Enemy grid controller: 5x12 alive mask, frame-paced march/drop, hit clearing and scoring.
// All state advances once per frame on the vsync rising edge.
module enemy_formation #(
    parameter int COL_PITCH   = 40,
    parameter int ROW_PITCH   = 32,
    parameter int STEP_X      = 4,
    parameter int DROP_Y      = 16,
    parameter int START_X     = 80,
    parameter int START_Y     = 64,
    parameter int LEFT_LIMIT  = 0,
    parameter int RIGHT_LIMIT = 640,
    parameter int INVADE_Y    = 400
) (
    input  logic        vsync,
    input  logic        reset,
    input  logic [3:0]  state,
    input  logic        hit_valid,
    input  logic [2:0]  hit_row,
    input  logic [3:0]  hit_col,
    output logic [59:0] enemy_array,
    output logic [9:0]  formation_x,
    output logic [9:0]  formation_y,
    output logic [15:0] score,
    output logic        invaded
);
    typedef enum logic [3:0] {
        ST_PRESS = 4'd0,
        ST_PLAY  = 4'd1,
        ST_WIN   = 4'd2,
        ST_OVER  = 4'd3
    } game_state_t;

    typedef enum logic {DIR_RIGHT = 1'b0, DIR_LEFT = 1'b1} dir_t;

    localparam int unsigned ROWS = 5;
    localparam int unsigned COLS = 12;

    localparam logic [12:0] COL_P    = 13'(COL_PITCH);
    localparam logic [12:0] ROW_P    = 13'(ROW_PITCH);
    localparam logic [12:0] STEP_W   = 13'(STEP_X);
    localparam logic [12:0] LEFT_W   = 13'(LEFT_LIMIT);
    localparam logic [12:0] RIGHT_W  = 13'(RIGHT_LIMIT);
    localparam logic [12:0] INVADE_W = 13'(INVADE_Y);
    localparam logic [9:0]  STEP_XW  = 10'(STEP_X);
    localparam logic [9:0]  DROP_YW  = 10'(DROP_Y);

    dir_t        dir;
    logic [3:0]  frame_cnt;

    logic [5:0]  alive_cnt;
    logic [11:0] col_any;
    logic [4:0]  row_any;
    logic [3:0]  left_col;
    logic [3:0]  right_col;
    logic [2:0]  bottom_row;
    logic [4:0]  period;
    logic        step_due;
    logic [12:0] edge_left;
    logic [12:0] edge_right;
    logic [12:0] edge_bottom;

    logic        hit_ok;
    logic [5:0]  hit_idx;
    logic [59:0] hit_mask;
    logic [4:0]  hit_pts;
    logic [16:0] score_sum;

    always_comb begin
        alive_cnt = '0;
        col_any   = '0;
        row_any   = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned c = 0; c < COLS; c++) begin
                if (enemy_array[r*COLS + c]) begin
                    alive_cnt  = alive_cnt + 6'd1;
                    col_any[c] = 1'b1;
                    row_any[r] = 1'b1;
                end
            end
        end

        // Ascending scans: last match wins, giving max for R/B and min for L.
        left_col   = '0;
        right_col  = '0;
        bottom_row = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            if (col_any[c])          right_col = 4'(c);
            if (col_any[COLS-1-c])   left_col  = 4'(COLS - 1 - c);
        end
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (row_any[r]) bottom_row = 3'(r);
        end

        period   = 5'(alive_cnt >> 2) + 5'd1;
        step_due = ({1'b0, frame_cnt} + 5'd1) >= period;

        edge_left   = 13'(formation_x) + 13'(left_col) * COL_P;
        edge_right  = 13'(formation_x) + (13'(right_col) + 13'd1) * COL_P;
        edge_bottom = 13'(formation_y) + (13'(bottom_row) + 13'd1) * ROW_P;

        hit_idx   = 6'(hit_row) * 6'd12 + 6'(hit_col);
        hit_ok    = hit_valid && (hit_row <= 3'd4) && (hit_col <= 4'd11) && enemy_array[hit_idx];
        hit_mask  = hit_ok ? (60'd1 << hit_idx) : '0;
        hit_pts   = (hit_row == 3'd0) ? 5'd30 : (hit_row <= 3'd2) ? 5'd20 : 5'd10;
        score_sum = {1'b0, score} + 17'(hit_pts);
    end

    always_ff @(posedge vsync or posedge reset) begin
        if (reset) begin
            enemy_array <= '1;
            formation_x <= 10'(START_X);
            formation_y <= 10'(START_Y);
            score       <= '0;
            invaded     <= 1'b0;
            dir         <= DIR_RIGHT;
            frame_cnt   <= '0;
        end else begin
            case (state)
                ST_PRESS: begin
                    enemy_array <= '1;
                    formation_x <= 10'(START_X);
                    formation_y <= 10'(START_Y);
                    score       <= '0;
                    invaded     <= 1'b0;
                    dir         <= DIR_RIGHT;
                    frame_cnt   <= '0;
                end
                ST_PLAY: begin
                    enemy_array <= enemy_array & ~hit_mask;
                    if (hit_ok) score <= score_sum[16] ? '1 : score_sum[15:0];
                    // Movement and pacing are judged on the pre-hit mask.
                    if (|enemy_array) begin
                        if (edge_bottom >= INVADE_W) invaded <= 1'b1;
                        if (step_due) begin
                            frame_cnt <= '0;
                            if (dir == DIR_RIGHT) begin
                                if (edge_right + STEP_W > RIGHT_W) begin
                                    formation_y <= formation_y + DROP_YW;
                                    dir         <= DIR_LEFT;
                                end else begin
                                    formation_x <= formation_x + STEP_XW;
                                end
                            end else begin
                                if (edge_left < LEFT_W + STEP_W) begin
                                    formation_y <= formation_y + DROP_YW;
                                    dir         <= DIR_RIGHT;
                                end else begin
                                    formation_x <= formation_x - STEP_XW;
                                end
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 4'd1;
                        end
                    end
                end
                ST_WIN, ST_OVER: ;
                default: ;
            endcase
        end
    end

endmodule
